// File: rtl/ex_mul_unit.sv
// ex_mul_unit: iterative shift-add multiplier for the EX stage.
//
// A request is captured from the EX-stage registers when the unit is IDLE
// or DONE. The unit then performs one shift-add step per cycle until the
// remaining multiplier bits are exhausted. It raises a one-cycle mul_done
// pulse with the low XLEN bits of the product.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   EX_mul      multiply request (EX-stage register output)
//   EX_a, EX_b  multiplicand / multiplier
//   EX_rd       destination register tag
//   flush       abort of any in-flight multiply
//   mul_busy    stall request to upstream stages (combinational)
//   mul_done    one-cycle result-valid pulse
//   mul_result  product, low XLEN bits (holds until next capture/reset)
//   mul_rd      destination register tag of the result
module ex_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_mul,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic [4:0]      EX_rd,
  input  logic            flush,
  output logic            mul_busy,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result,
  output logic [4:0]      mul_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_r, state_s;
  logic [XLEN-1:0] a_r, a_s;
  logic [XLEN-1:0] b_r, b_s;
  logic [XLEN-1:0] acc_r, acc_s;
  logic [4:0]      rd_r, rd_s;
  logic            done_r;
  logic            accept_s;

  // A new request can only be taken when no operation is iterating.
  assign accept_s = EX_mul && !flush;

  // Next-state and datapath update for capture and shift-add iteration.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    acc_s   = acc_r;
    rd_s    = rd_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          a_s   = EX_a;
          b_s   = EX_b;
          rd_s  = EX_rd;
          acc_s = {XLEN{1'b0}};
          // A zero operand needs no iterations: the cleared acc is the product.
          if ((EX_a == {XLEN{1'b0}}) || (EX_b == {XLEN{1'b0}})) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          // Abort: acc is left as-is but never reported as a result.
          state_s = ST_IDLE;
        end else begin
          if (b_r[0]) begin
            acc_s = acc_r + a_r;
          end else begin
            acc_s = acc_r;
          end
          a_s = {a_r[XLEN-2:0], 1'b0};
          b_s = {1'b0, b_r[XLEN-1:1]};
          // Finish on the step that consumes the last set multiplier bit.
          if (b_r[XLEN-1:1] == {(XLEN-1){1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_BUSY;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      acc_r   <= {XLEN{1'b0}};
      rd_r    <= 5'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      acc_r   <= acc_s;
      rd_r    <= rd_s;
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Stall upstream while iterating, or in the cycle a request is accepted.
  always_comb begin
    if (state_r == ST_BUSY) begin
      mul_busy = 1'b1;
    end else begin
      mul_busy = accept_s;
    end
  end

  assign mul_done   = done_r;
  assign mul_result = acc_r;
  assign mul_rd     = rd_r;

endmodule

// File: tb/tb_ex_mul_unit.sv
// tb_ex_mul_unit: self-checking bench for ex_mul_unit.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge. Expected values come from plain arithmetic:
// the product is a*b mod 2^32. The iteration count is the position of the
// highest set multiplier bit plus one.
module tb_ex_mul_unit;

  logic        clk;
  logic        rst;
  logic        EX_mul;
  logic [31:0] EX_a;
  logic [31:0] EX_b;
  logic [4:0]  EX_rd;
  logic        flush;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_result;
  logic [4:0]  mul_rd;

  int checks;
  int errors;

  ex_mul_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .EX_mul     (EX_mul),
    .EX_a       (EX_a),
    .EX_b       (EX_b),
    .EX_rd      (EX_rd),
    .flush      (flush),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .mul_rd     (mul_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of busy cycles the reference expects for one multiply.
  function automatic int ref_iters(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'd0 || b == 32'd0) return 0;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Track one multiply from capture to its done cycle.
  // captured=1: the request was already taken in the previous cycle.
  // chain=1: the follow-up request is presented in the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input bit captured, input bit chain,
                        input logic [31:0] na, input logic [31:0] nb, input logic [4:0] nrd);
    int n;
    logic [31:0] prod;
    n = ref_iters(a, b);
    prod = a * b;
    if (!captured) begin
      EX_mul = 1'b1; EX_a = a; EX_b = b; EX_rd = rd;
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b1 || mul_done !== 1'b0) begin
        errors++;
        $display("FAIL capture_cycle a=%h b=%h: busy=%b done=%b required busy=1 done=0",
                 a, b, mul_busy, mul_done);
      end
      next_cycle();
      EX_mul = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b1 || mul_done !== 1'b0) begin
        errors++;
        $display("FAIL busy_cycle a=%h b=%h k=%0d: busy=%b done=%b required busy=1 done=0",
                 a, b, k, mul_busy, mul_done);
      end
      next_cycle();
    end
    if (chain) begin
      EX_mul = 1'b1; EX_a = na; EX_b = nb; EX_rd = nrd;
    end else begin
      EX_mul = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (mul_done !== 1'b1 || mul_result !== prod || mul_rd !== rd || mul_busy !== chain) begin
      errors++;
      $display("FAIL done_cycle a=%h b=%h: done=%b result=%h rd=%0d busy=%b required done=1 result=%h rd=%0d busy=%b",
               a, b, mul_done, mul_result, mul_rd, mul_busy, prod, rd, chain);
    end
    next_cycle();
    EX_mul = 1'b0;
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (mul_done !== 1'b0 || mul_result !== prod || mul_busy !== 1'b0) begin
        errors++;
        $display("FAIL after_done a=%h b=%h: done=%b result=%h busy=%b required done=0 result=%h busy=0",
                 a, b, mul_done, mul_result, mul_busy, prod);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; EX_mul = 1'b0; flush = 1'b0; EX_a = 32'd0; EX_b = 32'd0; EX_rd = 5'd0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_result !== 32'd0 || mul_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h rd=%0d required all 0",
               mul_busy, mul_done, mul_result, mul_rd);
    end
    next_cycle();
  endtask

  task automatic test_basic();
    run_op(32'd7, 32'd6, 5'd5, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_op(32'd9, 32'd0, 5'd1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_op(32'd0, 32'd123, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_op(32'h1234_5678, 32'd1, 5'd31, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_wrap();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_op(32'h8000_0001, 32'h8000_0000, 5'd3, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_flush();
    // A request presented together with flush must be ignored.
    EX_mul = 1'b1; flush = 1'b1; EX_a = 32'd5; EX_b = 32'd5; EX_rd = 5'd2;
    @(negedge clk);
    checks++;
    if (mul_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_busy: busy=%b required 0", mul_busy);
    end
    next_cycle();
    EX_mul = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_nocapture: busy=%b done=%b required 0 0", mul_busy, mul_done);
    end
    next_cycle();
    // Abort an 8-iteration multiply in its second busy cycle.
    EX_mul = 1'b1; EX_a = 32'd3; EX_b = 32'h80; EX_rd = 5'd9;
    next_cycle();
    EX_mul = 1'b0;
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int k = 3; k < 14; k++) begin
      @(negedge clk);
      checks++;
      if (mul_busy !== 1'b0 || mul_done !== 1'b0) begin
        errors++;
        $display("FAIL flush_abort cycle=%0d: busy=%b done=%b required 0 0", k, mul_busy, mul_done);
      end
      next_cycle();
    end
    run_op(32'd2, 32'd2, 5'd4, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_back_to_back();
    run_op(32'd7, 32'd6, 5'd5, 1'b0, 1'b1, 32'd5, 32'd9, 5'd12);
    run_op(32'd5, 32'd9, 5'd12, 1'b1, 1'b1, 32'd0, 32'd8, 5'd1);
    run_op(32'd0, 32'd8, 5'd1, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_reset_mid();
    EX_mul = 1'b1; EX_a = 32'hFFFF_FFFF; EX_b = 32'hFFFF_FFFF; EX_rd = 5'd17;
    next_cycle();
    EX_mul = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_result !== 32'd0 || mul_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h rd=%0d required all 0",
               mul_busy, mul_done, mul_result, mul_rd);
    end
    for (int k = 0; k < 36; k++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (mul_done !== 1'b0 || mul_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nodone k=%0d: done=%b busy=%b required 0 0", k, mul_done, mul_busy);
      end
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] a, b, na, nb;
    logic [4:0]  rd, nrd;
    bit          chained;
    bit          chain;
    a = $urandom; b = $urandom >> $urandom_range(0, 31); rd = 5'($urandom);
    chained = 1'b0;
    for (int i = 0; i < 24; i++) begin
      na = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      nb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) nb = 32'd0;
      nrd = 5'($urandom);
      chain = (i != 23) && ($urandom_range(0, 1) == 1);
      run_op(a, b, rd, chained, chain, na, nb, nrd);
      a = na; b = nb; rd = nrd; chained = chain;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: EX_mul  input  1  multiply request from the EX-stage register outputs.
REQ-005 SHALL have port: EX_a  input  XLEN  multiplicand.
REQ-006 SHALL have port: EX_b  input  XLEN  multiplier.
REQ-007 SHALL have port: EX_rd  input  5  destination register of the multiply.
REQ-008 SHALL have port: flush  input  1  abort of any in-flight multiply.
REQ-009 SHALL have port: mul_busy  output  1  stall request to upstream stages (feeds stall_D).
REQ-010 SHALL have port: mul_done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: mul_result  output  XLEN  product, low XLEN bits.
REQ-012 SHALL have port: mul_rd  output  5  destination register tag of the result.

Function
REQ-013 SHALL implement three states: IDLE, BUSY, DONE.
REQ-014 SHALL, in IDLE or DONE with EX_mul=1 and flush=0, capture EX_a, EX_b and EX_rd into internal registers a_r, b_r and mul_rd, and clear accumulator acc.
REQ-015 SHALL, on that capture, go to DONE with acc=0 if EX_a==0 or EX_b==0, and otherwise go to BUSY.
REQ-016 SHALL, in IDLE or DONE with EX_mul=0 or flush=1, go to IDLE.
REQ-017 SHALL perform one shift-add iteration per cycle in BUSY: if b_r[0], acc <= acc + a_r (mod 2^XLEN); a_r <= a_r << 1 (MSB dropped); b_r <= b_r >> 1.
REQ-018 SHALL go from BUSY to DONE on the iteration where the shifted b_r becomes zero; iteration count = index of the highest set bit of EX_b + 1, max XLEN.
REQ-019 SHALL, with flush=1 in BUSY, go to IDLE next edge, discarding acc with no mul_done pulse; flush takes priority over iteration and completion.
REQ-020 SHALL drive mul_busy combinationally: IDLE/DONE -> EX_mul & ~flush; BUSY -> 1.
REQ-021 SHALL assert mul_done=1 only in the DONE state, for exactly one cycle per completed multiply.
REQ-022 SHALL drive mul_result = acc; it holds its value until the next capture or reset and is valid when mul_done=1.
REQ-023 SHALL present mul_rd as captured; rd=0 is computed and signalled normally (the writeback stage ignores x0).
REQ-024 SHALL have latency from capture cycle C to mul_done of: C+1 for zero operands; C+N+1 for N iterations.
REQ-025 SHALL accept a new request in the DONE cycle (back-to-back); mul_done still pulses for the completing operation.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, enter IDLE and clear a_r, b_r, acc and mul_rd to 0, regardless of state; rst overrides EX_mul and flush.
REQ-027 SHALL, after reset, present mul_busy=0 (given EX_mul=0), mul_done=0, mul_result=0 and mul_rd=0.
REQ-028 SHALL, when reset occurs mid-BUSY, produce no mul_done pulse for the aborted operation.

Verification
REQ-029 SHALL be verified for reset: rst=1 for 2 cycles, EX_mul=0 -> mul_busy=0, mul_done=0, mul_result=0, mul_rd=0.
REQ-030 SHALL be verified for a basic multiply: EX_mul=1, a=7, b=6, rd=5 in cycle 0 -> mul_busy=1 in cycles 0-3; mul_done=1 only in cycle 4 with mul_result=42, mul_rd=5; mul_busy=0 in cycle 4.
REQ-031 SHALL be verified for a zero operand: a=9, b=0 in cycle 0 -> mul_busy=1 only in cycle 0; mul_done=1 in cycle 1 with mul_result=0.
REQ-032 SHALL be verified for wrap-around: a=0xFFFFFFFF, b=0xFFFFFFFF -> 32 BUSY cycles; mul_done in cycle 33 with mul_result=0x00000001.
REQ-033 SHALL be verified for flush: a=3, b=0x80, flush=1 in cycle 2 -> IDLE in cycle 3 with mul_busy=0 and no mul_done pulse; a following request a=2, b=2 -> mul_result=4.
REQ-034 SHALL be verified for reset mid-operation: rst=1 in cycle 3 of a 32-iteration multiply -> IDLE next cycle with all outputs 0 and no mul_done pulse.
